// File: rtl/sensor_data_bank_pkg.sv
// Shared types for the sensor sample bank: read request and read status.
package sensor_bank_pkg;
  // Widest read address for NCH up to 256; narrower buses are zero-extended.
  localparam int MAX_AW = 8;

  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic              valid;
  } rd_req_t;

  typedef struct packed {
    logic valid;
    logic ovr;
    logic err;
    logic drop;
  } rd_stat_t;
endpackage

// File: rtl/sensor_data_bank_if.sv
// Producer/consumer signal bundle of the sensor sample bank.
interface sensor_data_bank_if #(
  parameter int W   = 32,
  parameter int NCH = 4
);
  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   wr_en;
  logic [NCH*W-1:0] wr_data;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             hold;
  logic [W-1:0]     rd_data;
  logic             rd_valid;
  logic             rd_ovr;
  logic             rd_err;
  logic             rd_drop;
  logic [NCH-1:0]   fresh;
  logic             busy;

  modport master (
    output wr_en, wr_data, rd_req, rd_addr, hold,
    input  rd_data, rd_valid, rd_ovr, rd_err, rd_drop, fresh, busy
  );

  modport slave (
    input  wr_en, wr_data, rd_req, rd_addr, hold,
    output rd_data, rd_valid, rd_ovr, rd_err, rd_drop, fresh, busy
  );
endinterface

// File: rtl/sensor_data_bank_rd_pending.sv
// One-entry pending slot for reads: parks a request under hold, drains it
// on the first hold-free cycle, drops any request arriving while it is full.
module sensor_rd_pending
  import sensor_bank_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    hold_i,
  input  rd_req_t req_i,
  output rd_req_t acc_o,
  output logic    drop_o,
  output logic    busy_o
);
  rd_req_t slot_q, slot_d;

  always_comb begin
    acc_o  = '0;
    drop_o = 1'b0;
    slot_d = slot_q;
    if (slot_q.valid) begin
      // The older request always wins, even on the drain cycle.
      drop_o = req_i.valid;
      if (!hold_i) begin
        acc_o  = slot_q;
        slot_d = '0;
      end
    end else if (req_i.valid) begin
      if (hold_i) slot_d = req_i;
      else        acc_o  = req_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) slot_q <= '0;
    else      slot_q <= slot_d;
  end

  assign busy_o = slot_q.valid;
endmodule

// File: rtl/sensor_data_bank.sv
// Bank of NCH sensor sample registers with per-channel write ports and a
// single addressed, holdable read port tracking fresh/overrun per channel.
module sensor_data_bank
  import sensor_bank_pkg::*;
#(
  parameter int W   = 32,
  parameter int NCH = 4
) (
  input logic               clk,
  input logic               rst,
  sensor_data_bank_if.slave bus
);
  logic [NCH-1:0][W-1:0] regs_q;
  logic [NCH-1:0]        fresh_q, fresh_d;
  logic [NCH-1:0]        ovr_q, ovr_d;
  logic [NCH-1:0]        rd_hit;
  logic [W-1:0]          rd_data_q, rd_data_d;
  logic [W-1:0]          sel_data;
  logic                  sel_ovr;
  rd_stat_t              stat_q, stat_d;
  rd_req_t               req, acc;
  logic                  drop, busy;

  assign req.valid = bus.rd_req;
  assign req.addr  = MAX_AW'(bus.rd_addr);

  sensor_rd_pending u_pend (
    .clk    (clk),
    .rst    (rst),
    .hold_i (bus.hold),
    .req_i  (req),
    .acc_o  (acc),
    .drop_o (drop),
    .busy_o (busy)
  );

  // A read of a channel consumes its old sample; a same-cycle write then
  // re-arms fresh without counting as an overrun.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign rd_hit[i]  = acc.valid && (acc.addr == MAX_AW'(i));
    assign fresh_d[i] = bus.wr_en[i] | (fresh_q[i] & ~rd_hit[i]);
    assign ovr_d[i]   = ~rd_hit[i] & (ovr_q[i] | (bus.wr_en[i] & fresh_q[i]));
  end

  always_comb begin
    sel_data = '0;
    sel_ovr  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_hit[i]) begin
        sel_data = regs_q[i];
        sel_ovr  = ovr_q[i];
      end
    end
  end

  // No channel hit on an accepted request means the address is out of range.
  always_comb begin
    stat_d      = '0;
    stat_d.ovr  = stat_q.ovr;
    stat_d.drop = drop;
    rd_data_d   = rd_data_q;
    if (acc.valid) begin
      if (|rd_hit) begin
        stat_d.valid = 1'b1;
        stat_d.ovr   = sel_ovr;
        rd_data_d    = sel_data;
      end else begin
        stat_d.err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q    <= '0;
      fresh_q   <= '0;
      ovr_q     <= '0;
      rd_data_q <= '0;
      stat_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (bus.wr_en[i]) regs_q[i] <= bus.wr_data[i*W +: W];
      fresh_q   <= fresh_d;
      ovr_q     <= ovr_d;
      rd_data_q <= rd_data_d;
      stat_q    <= stat_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = stat_q.valid;
  assign bus.rd_ovr   = stat_q.ovr;
  assign bus.rd_err   = stat_q.err;
  assign bus.rd_drop  = stat_q.drop;
  assign bus.fresh    = fresh_q;
  assign bus.busy     = busy;
endmodule

// File: doc/sensor_data_bank.md
Name: sensor_data_bank

Overview:
Parametrised bank of NCH sensor sample registers, each written by its own producer port, with a single addressed read port toward the bus/display side. Tracks per-channel fresh-data and overrun status. Read port has a hold input that freezes the output and defers read requests through a one-entry pending slot. Sits between the sensor interface front-ends and the consumer logic.

Parameters:
W, 32, data width of each channel register and of the read output
NCH, 4, number of channels (2..256)
AW, $clog2(NCH) (min 1), read address width; derived, not overridden

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
wr_en  in  NCH  per-channel write strobe, bit i for channel i
wr_data  in  NCH*W  packed write data, channel i at bits [i*W +: W]
rd_req  in  1  read request, one-cycle pulse per request
rd_addr  in  AW  channel to read, sampled with rd_req
hold  in  1  1 = freeze rd_data, defer reads
rd_data  out  W  registered read data
rd_valid  out  1  one-cycle pulse, rd_data/rd_ovr updated this cycle
rd_ovr  out  1  overrun flag of the channel just read
rd_err  out  1  one-cycle pulse, read of address >= NCH
rd_drop  out  1  one-cycle pulse, request lost (pending slot already full)
fresh  out  NCH  per-channel unread-data flag
busy  out  1  pending slot occupied

Behaviour:
- Reset (rst=0, async): all channel regs, fresh, ovr, rd_data = 0; rd_valid, rd_ovr, rd_err, rd_drop = 0; pending slot empty; busy = 0.
- Write: wr_en[i]=1 at edge -> reg[i] <= wr_data slice, fresh[i] <= 1. If fresh[i] was already 1 and channel i is not being read this cycle, ovr[i] <= 1. Multiple channels may write in the same cycle, independently.
- Read accept: request source is the pending slot if occupied, else rd_req/rd_addr. Accepted only when hold=0.
- Accepted read of a valid address a at edge t: at t+1 rd_data = reg[a] as held before edge t (pre-write value), rd_ovr = ovr[a], rd_valid = 1. Latency 1 cycle. fresh[a] and ovr[a] cleared at edge t, unless wr_en[a]=1 in the same cycle: then fresh[a] stays 1 and ovr[a] is cleared (the read consumed the old sample).
- Accepted read of address >= NCH: rd_err = 1 at t+1, rd_valid = 0, rd_data and rd_ovr unchanged, no flag changes.
- hold=1: rd_data and rd_ovr keep their value, rd_valid = 0. An rd_req while hold=1 and the slot is empty is stored in the slot, busy = 1. An rd_req while the slot is occupied (any hold state) -> rd_drop = 1 next cycle, request discarded, slot keeps the older request.
- Slot drains on the first cycle with hold=0. A fresh rd_req in that same cycle is dropped (rd_drop). busy clears with the accept.
- Writes are never blocked by hold or by reads.
- rd_valid, rd_err and rd_drop are pulses. Outputs change only on clk edges or reset.
- Reset mid-operation clears the pending slot. No read completes after reset.

Decomposition:
- Package sensor_bank_pkg: read request struct (addr, valid), read status struct (valid, ovr, err, drop).
- One natural sub-module: sensor_rd_pending, the one-entry pending slot with hold/drain/drop logic. Channel array and flags stay in the top level.

Test Plan:
- Reset, then read ch0..3 (NCH=4, W=32) -> rd_data=0, rd_ovr=0, rd_valid pulse 1 cycle after each rd_req, fresh=4'b0000.
- Write ch2=0xDEADBEEF, then read ch2 -> rd_data=0xDEADBEEF one cycle later, fresh[2]: 1->0.
- Write ch1=0x11 then 0x22, no read between -> read ch1 gives rd_data=0x22, rd_ovr=1. A second read gives rd_ovr=0.
- Same-cycle write ch3=0x55 and read ch3 (old value 0x44) -> rd_data=0x44, fresh[3]=1, ovr[3]=0. Next read gives 0x55.
- hold=1, rd_req ch0, then rd_req ch1 -> busy=1, rd_drop pulse for ch1, rd_data frozen. Release hold -> ch0 data returned 1 cycle later.
- NCH=3: rd_req addr 3 -> rd_err pulse, rd_valid=0, rd_data unchanged. Assert rst=0 with the slot occupied -> busy=0 immediately.
